plab2_proc_muldiv_unit: RTL and testbench
=========================================

Name: plab2_proc_muldiv_unit

Overview:
- Parametrised iterative integer multiply/divide unit; successor to the fixed-function variable-latency multiplier used by the stall-pipelined processor.
- Adds configurable operand width, signed/unsigned divide and remainder, and an optional early-termination mode for multiply.
- Sits beside the X-stage ALU. D stage issues requests over a val/rdy handshake; X stage consumes responses over a val/rdy handshake.

Parameters:
- NBITS, 32, operand and result width in bits; must be >= 4.
- EARLY_TERM, 1, when 1 a multiply stops iterating once the remaining multiplier bits are all zero; when 0 it always runs NBITS iterations.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_val  input  1  request valid.
- req_rdy  output  1  unit can accept a request.
- req_func  input  3  0=MUL, 1=DIV, 2=DIVU, 3=REM, 4=REMU, 5-7=invalid.
- req_a  input  NBITS  operand a: multiplicand or dividend.
- req_b  input  NBITS  operand b: multiplier or divisor.
- resp_val  output  1  result valid.
- resp_rdy  input  1  consumer accepts the result.
- resp_data  output  NBITS  result.

Behaviour:
- Reset:
  - While reset is low, regardless of clk: state=IDLE, req_rdy=1, resp_val=0, resp_data=0, counter and datapath registers cleared.
  - Reset asserted mid-operation abandons the operation; no response is ever produced for it.
- States: IDLE, CALC, DONE.
  - req_rdy = (state==IDLE).
  - resp_val = (state==DONE).
- IDLE:
  - On req_val && req_rdy, latch func, a and b, then go to CALC. Call the accept edge t.
  - Signed ops (DIV, REM) latch operand magnitudes plus sign flags: quotient sign = sa^sb, remainder sign = sa.
- CALC:
  - One iteration per cycle.
  - MUL: shift-add, low NBITS of the product kept. Signed and unsigned give identical low bits, so no sign handling.
  - DIV/DIVU/REM/REMU: restoring division, one quotient bit per iteration, NBITS iterations.
  - Counter width is clog2(NBITS)+1.
  - After the last iteration, one fix-up cycle applies sign correction and selects quotient or remainder, then the unit goes to DONE.
  - CALC occupancy = iterations + 1.
- Iteration counts:
  - MUL with EARLY_TERM=0: NBITS.
  - MUL with EARLY_TERM=1: index of the highest set bit of b, plus 1. b=0 gives 0 iterations.
  - Divides: NBITS.
  - Divisor == 0: 0 iterations. Quotient = all ones; remainder = a, unmodified, for both signed and unsigned.
  - Invalid func: 0 iterations, result 0.
- resp_val timing: first asserted at cycle t+2+iterations. Minimum latency is 2 cycles.
- Signed overflow: DIV of -2^(NBITS-1) by -1 gives -2^(NBITS-1); REM of the same gives 0. No trap, no special path required; the magnitude arithmetic wraps naturally.
- DONE:
  - resp_data is held stable while resp_val=1 && resp_rdy=0, for as many cycles as the stall lasts.
  - On resp_rdy, go to IDLE. req_rdy is 1 the next cycle.
  - No request is accepted in DONE, so there is at most one op in flight.
- Inputs are ignored outside IDLE. Latched operands are not affected by later changes on the req_* inputs.
- resp_data may carry intermediate values outside DONE; consumers qualify it with resp_val.

Test Plan:
- Reset/idle: hold reset low for 3 cycles with req_val=1 -> resp_val=0 and req_rdy=1 throughout; after release, no response appears without a new request.
- MUL, NBITS=32, EARLY_TERM=1:
  - a=7, b=6 -> resp_data=42; resp_val first at t+5 (3 iterations).
  - a=0xFFFFFFFF, b=0x80000000 -> 0x80000000 at t+34.
  - With EARLY_TERM=0, a=7, b=6 -> 42 at t+34.
- Signed divide/remainder:
  - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC; REMU -> 1.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
  - All at t+34.
- Divide by zero: DIVU 5/0 -> 0xFFFFFFFF; REM -5/0 -> 0xFFFFFFFB; both at t+2. Invalid func 6 -> 0 at t+2.
- Backpressure: hold resp_rdy=0 for 10 cycles after resp_val rises -> resp_data constant and req_rdy=0 throughout; a new req_val is not accepted until the cycle after resp_rdy=1.
- Reset mid-op: assert reset at t+10 of a DIV, then issue MUL 3*3 -> exactly one response, value 9, and no stale divide result.

Source files
------------

// File: rtl/plab2_proc_muldiv_unit.sv
// plab2_proc_muldiv_unit: iterative shift-add multiplier and restoring divider behind val/rdy handshakes
module plab2_proc_muldiv_unit #(
    parameter int NBITS = 32,
    parameter bit EARLY_TERM = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_val,
    output logic             req_rdy,
    input  logic [2:0]       req_func,
    input  logic [NBITS-1:0] req_a,
    input  logic [NBITS-1:0] req_b,
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic [NBITS-1:0] resp_data
);
    localparam int CW = $clog2(NBITS) + 1;
    localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
    localparam logic [2:0] MUL = 3'd0, DIV = 3'd1, DIVU = 3'd2, REM = 3'd3, REMU = 3'd4;
    logic [1:0] state_q, state_d;
    logic [2:0] func_q, func_d;
    logic [NBITS-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, res_q, res_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic qneg_q, qneg_d, rneg_q, rneg_d;
    logic sgn, sa, sb, is_mul, is_rem, fin;
    logic [NBITS:0] diff;
    always_comb begin
        sgn = req_func == DIV || req_func == REM;
        sa = sgn && req_a[NBITS-1];
        sb = sgn && req_b[NBITS-1];
        is_mul = func_q == MUL;
        is_rem = func_q == REM || func_q == REMU;
        diff = {acc_q, a_q[NBITS-1]} - {1'b0, b_q};
        fin = func_q > REMU || (is_mul ? (EARLY_TERM ? b_q == '0 : cnt_q == CW'(NBITS))
                                       : (b_q == '0 || cnt_q == CW'(NBITS)));
        state_d = state_q;
        func_d = func_q;
        a_d = a_q;
        b_d = b_q;
        acc_d = acc_q;
        res_d = res_q;
        cnt_d = cnt_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        if (state_q == IDLE && req_val) begin
            state_d = CALC;
            func_d = req_func;
            a_d = sa ? -req_a : req_a;
            b_d = sb ? -req_b : req_b;
            acc_d = '0;
            cnt_d = '0;
            qneg_d = sa ^ sb;
            rneg_d = sa;
        end else if (state_q == CALC && fin) begin
            // fix-up: zero divisor yields all ones / the untouched dividend
            state_d = DONE;
            res_d = func_q > REMU ? '0
                  : is_mul ? acc_q
                  : b_q == '0 ? (is_rem ? (rneg_q ? -a_q : a_q) : '1)
                  : is_rem ? (rneg_q ? -acc_q : acc_q)
                  : (qneg_q ? -a_q : a_q);
        end else if (state_q == CALC) begin
            cnt_d = cnt_q + 1'b1;
            acc_d = is_mul ? acc_q + (b_q[0] ? a_q : '0)
                  : (diff[NBITS] ? {acc_q[NBITS-2:0], a_q[NBITS-1]} : diff[NBITS-1:0]);
            a_d = is_mul ? a_q << 1 : {a_q[NBITS-2:0], ~diff[NBITS]};
            b_d = is_mul ? b_q >> 1 : b_q;
        end else if (state_q == DONE && resp_rdy) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            func_q <= '0;
            a_q <= '0;
            b_q <= '0;
            acc_q <= '0;
            res_q <= '0;
            cnt_q <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            func_q <= func_d;
            a_q <= a_d;
            b_q <= b_d;
            acc_q <= acc_d;
            res_q <= res_d;
            cnt_q <= cnt_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
        end
    end
    assign req_rdy = state_q == IDLE;
    assign resp_val = state_q == DONE;
    assign resp_data = res_q;
endmodule

// File: tb/tb_plab2_proc_muldiv_unit.sv
// tb_plab2_proc_muldiv_unit: vector table, random ops against an arithmetic model, and handshake/reset corner cases
module tb_plab2_proc_muldiv_unit;
    logic clk = 1'b0, reset = 1'b0;
    logic req_val = 1'b0, resp_rdy = 1'b0, req_val0 = 1'b0, resp_rdy0 = 1'b0;
    logic req_rdy, resp_val, req_rdy0, resp_val0;
    logic [2:0] req_func = '0;
    logic [31:0] req_a = '0, req_b = '0, resp_data, resp_data0;
    int n_chk = 0, n_fail = 0;

    plab2_proc_muldiv_unit #(.NBITS(32), .EARLY_TERM(1)) dut (
        .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(req_rdy), .req_func(req_func),
        .req_a(req_a), .req_b(req_b), .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_data(resp_data)
    );
    plab2_proc_muldiv_unit #(.NBITS(32), .EARLY_TERM(0)) dut0 (
        .clk(clk), .reset(reset), .req_val(req_val0), .req_rdy(req_rdy0), .req_func(req_func),
        .req_a(req_a), .req_b(req_b), .resp_val(resp_val0), .resp_rdy(resp_rdy0), .resp_data(resp_data0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] f;
        logic [31:0] a, b, d;
        int lat;
    } vec_t;
    vec_t tv[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (f == 3'd0) return a * b;
        if (f == 3'd2) return b == 0 ? 32'hFFFFFFFF : a / b;
        if (f == 3'd4) return b == 0 ? a : a % b;
        if (f == 3'd1) begin
            if (b == 0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
            return sa / sb;
        end
        if (f == 3'd3) begin
            if (b == 0) return a;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 0;
            return sa % sb;
        end
        return 0;
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] b);
        if (f > 3'd4 || (f != 3'd0 && b == 0)) return 2;
        if (f != 3'd0) return 34;
        for (int i = 31; i >= 0; i--) if (b[i]) return i + 3;
        return 2;
    endfunction

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req_val = 1'b1;
        req_func = f;
        req_a = a;
        req_b = b;
        chk("req_rdy_idle", 32'(req_rdy), 32'd1);
        @(posedge clk);
    endtask

    task automatic wait_resp(input logic [31:0] exp_d, input int exp_lat, input string nm);
        int j;
        logic busy_rdy;
        @(negedge clk);
        req_val = 1'b0;
        req_a = $urandom;
        req_b = $urandom;
        req_func = 3'($urandom);
        j = 0;
        busy_rdy = 1'b0;
        while (!resp_val && j < 100) begin
            busy_rdy |= req_rdy;
            @(negedge clk);
            j++;
        end
        chk({nm, "_lat"}, 32'(j + 1), 32'(exp_lat));
        chk({nm, "_data"}, resp_data, exp_d);
        chk({nm, "_busy_rdy"}, 32'(busy_rdy), 32'd0);
    endtask

    task automatic finish_resp();
        resp_rdy = 1'b1;
        @(negedge clk);
        resp_rdy = 1'b0;
        chk("rdy_after_resp", 32'(req_rdy), 32'd1);
        chk("val_after_resp", 32'(resp_val), 32'd0);
    endtask

    initial begin
        int j, cnt;
        logic [2:0] f;
        logic [31:0] a, b;
        tv[0]  = '{3'd0, 32'd7, 32'd6, 32'd42, 5};
        tv[1]  = '{3'd0, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 34};
        tv[2]  = '{3'd1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34};
        tv[3]  = '{3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34};
        tv[4]  = '{3'd2, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 34};
        tv[5]  = '{3'd4, 32'hFFFFFFF9, 32'd2, 32'd1, 34};
        tv[6]  = '{3'd1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34};
        tv[7]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 34};
        tv[8]  = '{3'd2, 32'd5, 32'd0, 32'hFFFFFFFF, 2};
        tv[9]  = '{3'd3, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 2};
        tv[10] = '{3'd1, 32'hFFFFFFF7, 32'd0, 32'hFFFFFFFF, 2};
        tv[11] = '{3'd6, 32'd12, 32'd3, 32'd0, 2};
        tv[12] = '{3'd5, 32'd12, 32'd3, 32'd0, 2};
        tv[13] = '{3'd0, 32'd5, 32'd0, 32'd0, 2};
        tv[14] = '{3'd0, 32'd3, 32'd1, 32'd3, 3};
        tv[15] = '{3'd1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 34};

        req_val = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_resp_val", 32'(resp_val), 32'd0);
            chk("rst_req_rdy", 32'(req_rdy), 32'd1);
        end
        reset = 1'b1;
        req_val = 1'b0;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            cnt += int'(resp_val);
        end
        chk("idle_no_resp", 32'(cnt), 32'd0);

        for (int i = 0; i < 16; i++) begin
            issue(tv[i].f, tv[i].a, tv[i].b);
            wait_resp(tv[i].d, tv[i].lat, $sformatf("vec%0d", i));
            finish_resp();
        end

        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 4));
            a = $urandom_range(0, 7) == 0 ? 32'h80000000 : $urandom;
            j = $urandom_range(0, 4);
            b = j == 0 ? 32'd0 : j == 1 ? 32'($urandom_range(1, 255)) : j == 2 ? 32'hFFFFFFFF : $urandom;
            issue(f, a, b);
            wait_resp(ref_res(f, a, b), ref_lat(f, b), $sformatf("rand%0d_f%0d", i, f));
            finish_resp();
        end

        issue(3'd1, 32'd100, 32'd7);
        wait_resp(32'd14, 34, "bp_div");
        req_val = 1'b1;
        req_func = 3'd0;
        req_a = 32'd3;
        req_b = 32'd4;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_val", 32'(resp_val), 32'd1);
            chk("bp_data", resp_data, 32'd14);
            chk("bp_req_rdy", 32'(req_rdy), 32'd0);
        end
        resp_rdy = 1'b1;
        @(negedge clk);
        resp_rdy = 1'b0;
        chk("bp_rdy_after", 32'(req_rdy), 32'd1);
        @(posedge clk);
        wait_resp(32'd12, 5, "bp_next_mul");
        finish_resp();

        issue(3'd1, 32'd1000, 32'd3);
        @(negedge clk);
        req_val = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_val", 32'(resp_val), 32'd0);
        chk("midrst_rdy", 32'(req_rdy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        issue(3'd0, 32'd3, 32'd3);
        wait_resp(32'd9, 4, "midrst_mul");
        finish_resp();
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            cnt += int'(resp_val);
        end
        chk("midrst_no_stale", 32'(cnt), 32'd0);

        @(negedge clk);
        req_val0 = 1'b1;
        req_func = 3'd0;
        req_a = 32'd7;
        req_b = 32'd6;
        chk("et0_rdy", 32'(req_rdy0), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_val0 = 1'b0;
        j = 0;
        while (!resp_val0 && j < 100) begin
            @(negedge clk);
            j++;
        end
        chk("et0_lat", 32'(j + 1), 32'd34);
        chk("et0_data", resp_data0, 32'd42);
        resp_rdy0 = 1'b1;
        @(negedge clk);
        resp_rdy0 = 1'b0;
        chk("et0_rdy_after", 32'(req_rdy0), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
